// File: rtl/operand_stack.sv
// Operand stack for a small expression evaluator.
// The top two entries are visible combinationally; each cycle performs at
// most one operation: push, pop, replace top, pop two, or binary-op
// (consume two, write one). A failed operation leaves the stack unchanged
// and sets a sticky error flag.
module operand_stack #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [WIDTH-1:0]             wr_data,
    input  logic                         wr_en,
    input  logic                         re_en_a,
    input  logic                         re_en_b,
    input  logic                         clear_err,
    output logic [WIDTH-1:0]             re_data_a,
    output logic [WIDTH-1:0]             re_data_b,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         empty,
    output logic                         full,
    output logic                         overflow,
    output logic                         underflow,
    output logic                         illegal
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [CW-1:0]    r_count;
    logic             r_overflow;
    logic             r_underflow;
    logic             r_illegal;

    logic [2:0]       w_op;
    logic             w_ge1;
    logic             w_ge2;
    logic             w_full;
    logic [IW-1:0]    w_push_idx;
    logic [IW-1:0]    w_top_idx;
    logic [IW-1:0]    w_sec_idx;
    logic [CW-1:0]    w_next_count;
    logic             w_mem_we;
    logic [IW-1:0]    w_mem_idx;
    logic             w_set_ovf;
    logic             w_set_udf;
    logic             w_set_ill;

    assign w_op   = {re_en_a, re_en_b, wr_en};
    assign w_ge1  = (r_count != CW'(0));
    assign w_ge2  = (r_count >= CW'(2));
    assign w_full = (r_count == CW'(DEPTH));

    // Index arithmetic is done modulo DEPTH: when count==DEPTH the low bits
    // are zero, so subtracting one still lands on the last entry.
    assign w_push_idx = r_count[IW-1:0];
    assign w_top_idx  = r_count[IW-1:0] - IW'(1);
    assign w_sec_idx  = r_count[IW-1:0] - IW'(2);

    // Decode the requested operation into next count, array write and error sets.
    always_comb begin
        w_next_count = r_count;
        w_mem_we     = 1'b0;
        w_mem_idx    = w_push_idx;
        w_set_ovf    = 1'b0;
        w_set_udf    = 1'b0;
        w_set_ill    = 1'b0;
        case (w_op)
            3'b000: begin
                w_next_count = r_count;
            end
            3'b001: begin
                if (w_full) begin
                    w_set_ovf = 1'b1;
                end else begin
                    w_mem_we     = 1'b1;
                    w_mem_idx    = w_push_idx;
                    w_next_count = r_count + CW'(1);
                end
            end
            3'b010: begin
                if (!w_ge1) begin
                    w_set_udf = 1'b1;
                end else begin
                    w_next_count = r_count - CW'(1);
                end
            end
            3'b011: begin
                if (!w_ge1) begin
                    w_set_udf = 1'b1;
                end else begin
                    w_mem_we  = 1'b1;
                    w_mem_idx = w_top_idx;
                end
            end
            3'b110: begin
                if (!w_ge2) begin
                    w_set_udf = 1'b1;
                end else begin
                    w_next_count = r_count - CW'(2);
                end
            end
            3'b111: begin
                if (!w_ge2) begin
                    w_set_udf = 1'b1;
                end else begin
                    w_mem_we     = 1'b1;
                    w_mem_idx    = w_sec_idx;
                    w_next_count = r_count - CW'(1);
                end
            end
            3'b100, 3'b101: begin
                w_set_ill = 1'b1;
            end
            default: begin
                w_set_ill = 1'b1;
            end
        endcase
    end

    // Array storage; contents are not reset since reads are masked by count.
    always_ff @(posedge clock) begin
        if (reset && w_mem_we) begin
            r_mem[w_mem_idx] <= wr_data;
        end
    end

    // Occupancy counter and sticky error flags; a new error wins over clear_err.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
            r_illegal   <= 1'b0;
        end else begin
            r_count     <= w_next_count;
            r_overflow  <= (r_overflow  & ~clear_err) | w_set_ovf;
            r_underflow <= (r_underflow & ~clear_err) | w_set_udf;
            r_illegal   <= (r_illegal   & ~clear_err) | w_set_ill;
        end
    end

    assign re_data_b = w_ge1 ? r_mem[w_top_idx] : '0;
    assign re_data_a = w_ge2 ? r_mem[w_sec_idx] : '0;
    assign count     = r_count;
    assign empty     = !w_ge1;
    assign full      = w_full;
    assign overflow  = r_overflow;
    assign underflow = r_underflow;
    assign illegal   = r_illegal;

endmodule

// File: tb/tb_operand_stack.sv
// Directed scoreboard bench for operand_stack (WIDTH=8, DEPTH=16).
// The stimulus task queues the expected post-edge state; a monitor process
// pops one entry after each rising edge and compares it with the outputs.
module tb_operand_stack;

    logic       clock;
    logic       reset;
    logic [7:0] wr_data;
    logic       wr_en;
    logic       re_en_a;
    logic       re_en_b;
    logic       clear_err;
    logic [7:0] re_data_a;
    logic [7:0] re_data_b;
    logic [4:0] count;
    logic       empty;
    logic       full;
    logic       overflow;
    logic       underflow;
    logic       illegal;

    typedef struct {
        logic [25:0] v;
        string       nm;
    } exp_t;

    exp_t sb[$];
    int   n_vec;
    int   n_err;

    operand_stack #(.WIDTH(8), .DEPTH(16)) dut (
        .clock     (clock),
        .reset     (reset),
        .wr_data   (wr_data),
        .wr_en     (wr_en),
        .re_en_a   (re_en_a),
        .re_en_b   (re_en_b),
        .clear_err (clear_err),
        .re_data_a (re_data_a),
        .re_data_b (re_data_b),
        .count     (count),
        .empty     (empty),
        .full      (full),
        .overflow  (overflow),
        .underflow (underflow),
        .illegal   (illegal)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Monitor: after every rising edge, check the oldest queued expectation.
    initial begin
        exp_t        e;
        logic [25:0] act;
        forever begin
            @(posedge clock);
            #1;
            if (sb.size() > 0) begin
                e   = sb.pop_front();
                act = {count, empty, full, overflow, underflow, illegal, re_data_a, re_data_b};
                n_vec++;
                if (act !== e.v) begin
                    n_err++;
                    $display("FAIL %s: got cnt=%0d e=%b f=%b o=%b u=%b i=%b a=%h b=%h, want cnt=%0d e=%b f=%b o=%b u=%b i=%b a=%h b=%h",
                             e.nm, act[25:21], act[20], act[19], act[18], act[17], act[16], act[15:8], act[7:0],
                             e.v[25:21], e.v[20], e.v[19], e.v[18], e.v[17], e.v[16], e.v[15:8], e.v[7:0]);
                end
            end
        end
    end

    // Apply one cycle of stimulus and queue the expected state after the edge.
    task automatic step(input logic [2:0] op, input logic [7:0] d, input logic rst_n, input logic clr,
                        input logic [4:0] c, input logic e, input logic f,
                        input logic o, input logic u, input logic i,
                        input logic [7:0] a, input logic [7:0] b, input string nm);
        exp_t x;
        @(negedge clock);
        reset     = rst_n;
        {re_en_a, re_en_b, wr_en} = op;
        wr_data   = d;
        clear_err = clr;
        x.v  = {c, e, f, o, u, i, a, b};
        x.nm = nm;
        sb.push_back(x);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        reset = 1'b0; wr_en = 1'b0; re_en_a = 1'b0; re_en_b = 1'b0;
        clear_err = 1'b0; wr_data = 8'h00;

        step(3'b000, 8'h00, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, "reset");

        // Binary-op replaces two operands by the result.
        step(3'b001, 8'h05, 1'b1, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h05, "push05");
        step(3'b001, 8'h03, 1'b1, 1'b0, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h05, 8'h03, "push03");
        step(3'b111, 8'h08, 1'b1, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h08, "binop08");
        step(3'b010, 8'h00, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, "pop_to_empty");

        // Replace top, then pop.
        step(3'b001, 8'h7F, 1'b1, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h7F, "push7F");
        step(3'b011, 8'h22, 1'b1, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h22, "replace22");
        step(3'b011, 8'h7F, 1'b1, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h7F, "replace7F");
        step(3'b010, 8'h00, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, "pop7F");

        // Fill to DEPTH, overflow, then binary-op on full.
        for (int k = 0; k < 16; k++) begin
            step(3'b001, 8'(k), 1'b1, 1'b0, 5'(k + 1), 1'b0, (k == 15), 1'b0, 1'b0, 1'b0,
                 (k >= 1) ? 8'(k - 1) : 8'h00, 8'(k), $sformatf("fill%0d", k));
        end
        step(3'b001, 8'hAA, 1'b1, 1'b0, 5'd16, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h0E, 8'h0F, "overflow");
        step(3'b111, 8'h55, 1'b1, 1'b0, 5'd15, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h0D, 8'h55, "binop_full");
        step(3'b000, 8'h00, 1'b1, 1'b1, 5'd15, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h0D, 8'h55, "clear_ovf");
        step(3'b110, 8'h00, 1'b1, 1'b0, 5'd13, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h0B, 8'h0C, "pop_two");

        // Underflow / illegal from reset, set-wins-over-clear.
        step(3'b000, 8'h00, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, "reset2");
        step(3'b010, 8'h00, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, "pop_empty");
        step(3'b100, 8'h00, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 8'h00, "illegal100");
        step(3'b001, 8'h44, 1'b1, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 8'h44, "push44");
        step(3'b110, 8'h00, 1'b1, 1'b1, 5'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h44, "clr_vs_udf");
        step(3'b101, 8'h99, 1'b1, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 8'h44, "illegal101");
        step(3'b111, 8'h66, 1'b1, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 8'h44, "binop_cnt1");
        step(3'b000, 8'h00, 1'b1, 1'b1, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h44, "clear_all");
        step(3'b010, 8'h00, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, "pop44");
        step(3'b011, 8'h33, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, "replace_empty");

        // Reset mid-operation.
        step(3'b001, 8'h01, 1'b1, 1'b1, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h01, "push01");
        step(3'b001, 8'h02, 1'b1, 1'b0, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h01, 8'h02, "push02");
        step(3'b001, 8'h03, 1'b1, 1'b0, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h02, 8'h03, "push03b");
        step(3'b100, 8'h00, 1'b1, 1'b0, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h02, 8'h03, "illegal_pre_rst");
        step(3'b001, 8'h99, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, "reset_with_push");
        step(3'b001, 8'h11, 1'b1, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h11, "push11");
        step(3'b000, 8'hEE, 1'b1, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h11, "hold");

        // Drain the scoreboard with a bounded wait.
        for (int w = 0; w < 10; w++) begin
            if (sb.size() != 0) @(posedge clock);
        end
        #2;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d expectations left, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/operand_stack.md
OPERAND_STACK -- requirements
Module: operand_stack

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, entry width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 16, number of entries (power of two, >= 4).
REQ-003 The block SHALL use one clock and a synchronous, active-low reset, with ports as follows:
REQ-004 clock  input  1  rising-edge clock for all state.
REQ-005 reset  input  1  synchronous, active-low; stack cleared when sampled 0 at a clock edge.
REQ-006 wr_data  input  WIDTH  value pushed or written.
REQ-007 wr_en  input  1  push request.
REQ-008 re_en_a  input  1  consume second-from-top entry.
REQ-009 re_en_b  input  1  consume top entry.
REQ-010 clear_err  input  1  clears sticky error flags.
REQ-011 re_data_a  output  WIDTH  second-from-top entry, combinational.
REQ-012 re_data_b  output  WIDTH  top entry, combinational.
REQ-013 count  output  clog2(DEPTH+1)  current occupancy.
REQ-014 empty, full  output  1 each  count==0, count==DEPTH.
REQ-015 overflow, underflow, illegal  output  1 each  sticky error flags.

Function
REQ-016 Storage: DEPTH x WIDTH register array plus occupancy counter; entry index count-1 is top.
REQ-017 re_data_b SHALL equal the top entry when count>=1, else 0; re_data_a SHALL equal entry count-2 when count>=2, else 0; both purely combinational from current state (zero-cycle read latency).
REQ-018 All updates SHALL take effect at the rising clock edge; one operation per cycle, selected by {re_en_a, re_en_b, wr_en}:
REQ-019 000: hold.
REQ-020 001 push: entry[count]<=wr_data, count+1; if full: no change, overflow<=1.
REQ-021 010 pop: count-1; if empty: no change, underflow<=1.
REQ-022 011 replace top: entry[count-1]<=wr_data, count unchanged; if empty: no change, underflow<=1.
REQ-023 110 pop two: count-2; if count<2: no change, underflow<=1.
REQ-024 111 binary-op: entry[count-2]<=wr_data, count-1; if count<2: no change, underflow<=1.
REQ-025 100 and 101: no stack change, illegal<=1.
REQ-026 A failed operation SHALL leave array, count, re_data_a and re_data_b unchanged.
REQ-027 111 and 011 SHALL NOT fail on full (net occupancy does not grow).
REQ-028 Popped array entries need not be cleared; outputs are masked by count per REQ-017.
REQ-029 clear_err=1 SHALL clear all three flags at the edge; if an error occurs in the same cycle, the flag SHALL be set (set wins).
REQ-030 count SHALL never exceed DEPTH nor go below 0; no wrap-around.

Reset
REQ-031 reset=0 at an edge SHALL force count=0, overflow=underflow=illegal=0, regardless of any other input, including mid-operation.
REQ-032 After reset: empty=1, full=0, re_data_a=re_data_b=0; array contents need not be reset.
REQ-033 Operations SHALL resume on the first edge with reset=1.

Verification
REQ-034 Push 0x05, push 0x03, then 111 with wr_data=0x08 -> count 1, re_data_b=0x08, re_data_a=0x00, no flags.
REQ-035 Push 0x7F, 011 with wr_data=0x7F, 010 -> after dup-style write count 1 top 0x7F; after pop count 0, empty=1, re_data_b=0.
REQ-036 Push DEPTH values 0..DEPTH-1, one more push 0xAA -> full=1, overflow=1, top=DEPTH-1, count=DEPTH; then 111 wr_data=0x55 succeeds, count=DEPTH-1, top=0x55.
REQ-037 From reset, 010 -> underflow=1, count 0; 100 -> illegal=1; clear_err with 110 on count 1 -> underflow stays 1, illegal cleared.
REQ-038 Push 3 values, assert reset=0 concurrently with wr_en=1 -> count 0, all flags 0, empty=1; next push 0x11 -> count 1, top 0x11.
